// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

  // Operand / HI / LO width used by the processor build.
  localparam int MDU_WIDTH = 32;

  // Operation codes carried on op, sampled together with start.
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } mdu_state_e;

  // Ceiling log2, used to size the iteration counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Latency: wires only; optional cancel signal present when MDU_CANCEL_EN is defined.
// Backpressure: none in-band; the consumer watches busy/stall and holds its instruction.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mf_req;
  logic             mf_hi;
`ifdef MDU_CANCEL_EN
  logic             cancel;
`endif
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

`ifdef MDU_CANCEL_EN
  modport master (
    output start, op, src_a, src_b, mf_req, mf_hi, cancel,
    input  result, hi, lo, busy, done, stall
  );
  modport slave (
    input  start, op, src_a, src_b, mf_req, mf_hi, cancel,
    output result, hi, lo, busy, done, stall
  );
`else
  modport master (
    output start, op, src_a, src_b, mf_req, mf_hi,
    input  result, hi, lo, busy, done, stall
  );
  modport slave (
    input  start, op, src_a, src_b, mf_req, mf_hi,
    output result, hi, lo, busy, done, stall
  );
`endif

endinterface

// File: rtl/mdu_iter.sv
// One iteration step: shift-add multiply or restoring-subtract divide on a 2*WIDTH accumulator.
// Latency: combinational.
// Backpressure: none; the caller decides when to register acc_o.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] acc_o
);

  // Multiply layout: acc = {partial product, remaining multiplier bits}.
  // Divide layout:   acc = {partial remainder, dividend bits / quotient bits}.
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Single step; the divide borrow bit (diff MSB) selects restore vs. keep.
  always_comb begin
    add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
    rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff    = rem_sh - {1'b0, operand_i};
    acc_o   = {add_sum, acc_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (diff[WIDTH]) begin
        acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owning HI/LO; optional flush input under MDU_CANCEL_EN.
// Latency: start accepted at edge N -> HI/LO written, done pulsed after edge N+WIDTH+2; MTHI/MTLO on edge N.
// Backpressure: start is dropped while busy (and in the done cycle); stall = mf_req & busy for the hazard unit.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input logic clk,
  input logic reset,
  mdu_if.slave mdu
);

  localparam int CW = clog2(WIDTH);

  mdu_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q;
  logic               is_sgn_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               flush;
  logic               accept;

`ifdef MDU_CANCEL_EN
  assign flush = mdu.cancel;
`else
  assign flush = 1'b0;
`endif

  // The done cycle still belongs to the finishing operation, so a start
  // there is dropped; the following cycle accepts normally.
  assign accept = mdu.start && (state_q == IDLE) && !done_q && !flush;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div_i  (is_div_q),
    .operand_i (opnd_q),
    .acc_i     (acc_q),
    .acc_o     (acc_d)
  );

  // Operand magnitudes and signs for the PREP cycle.
  always_comb begin
    a_neg = is_sgn_q & a_q[WIDTH-1];
    b_neg = is_sgn_q & b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
  end

  // Sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    prod_fix = neg_quo_q ? -acc_q : acc_q;
    quo_fix  = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
    lo_d     = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        hi_d = a_q;
        lo_d = {WIDTH{1'b1}};
      end else begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end
    end
  end

  // Control FSM with counter, datapath registers and HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      is_sgn_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush && busy_q) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              case (mdu.op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  a_q      <= mdu.src_a;
                  b_q      <= mdu.src_b;
                  is_div_q <= mdu.op[1];
                  is_sgn_q <= ~mdu.op[0];
                  busy_q   <= 1'b1;
                  state_q  <= PREP;
                end
                OP_MTHI: hi_q <= mdu.src_a;
                OP_MTLO: lo_q <= mdu.src_a;
                default: ;
              endcase
            end
          end
          PREP: begin
            acc_q     <= is_div_q ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opnd_q    <= is_div_q ? b_mag : a_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= is_div_q && (b_q == '0);
            cnt_q     <= CW'(WIDTH - 1);
            state_q   <= ITER;
          end
          ITER: begin
            acc_q <= acc_d;
            if (cnt_q == '0) begin
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          FIX: begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mdu.result = mdu.mf_hi ? hi_q : lo_q;
  assign mdu.hi     = hi_q;
  assign mdu.lo     = lo_q;
  assign mdu.busy   = busy_q;
  assign mdu.done   = done_q;
  assign mdu.stall  = mdu.mf_req & busy_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed HI/LO results.
// Latency: expects done WIDTH+2 edges after the accepting edge.
// Backpressure: exercises stall, start-while-busy, async reset abort and (MDU_CANCEL_EN) cancel.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mdu_if #(.WIDTH(32)) m ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents start for one edge; returns #1 after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    m.start = 1'b1;
    m.op    = o;
    m.src_a = a;
    m.src_b = b;
    tick();
    m.start = 1'b0;
  endtask

  // Waits for done (bounded), counting edges and busy-high samples.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = m.busy ? 1 : 0;
    while (!m.done && cyc < 200) begin
      tick();
      cyc++;
      if (m.busy) bcnt++;
    end
    if (cyc >= 200) check("done_timeout", 64'(m.done), 64'd1);
  endtask

  // Full mult/div operation, then one idle cycle so done has dropped.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    int bcnt;
    issue(o, a, b);
    wait_done(cyc, bcnt);
    check({tag, "_lat"}, 64'(cyc), 64'd34);
    check({tag, "_hi"}, 64'(m.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(m.lo), 64'(exp_lo));
    tick();
  endtask

  initial begin
    int cyc;
    int bcnt;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    m.start = 1'b0;
    m.op    = 3'd0;
    m.src_a = '0;
    m.src_b = '0;
    m.mf_req = 1'b0;
    m.mf_hi  = 1'b0;
`ifdef MDU_CANCEL_EN
    m.cancel = 1'b0;
`endif
    tick();
    check("rst_busy", 64'(m.busy), 64'd0);
    check("rst_done", 64'(m.done), 64'd0);
    check("rst_hi", 64'(m.hi), 64'd0);
    check("rst_lo", 64'(m.lo), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // MULTU with latency and busy-width measurement.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    check("multu_busy_rise", 64'(m.busy), 64'd1);
    check("multu_hi_hold", 64'(m.hi), 64'd0);
    wait_done(cyc, bcnt);
    check("multu_lat", 64'(cyc), 64'd34);
    check("multu_busy_cycles", 64'(bcnt), 64'd34);
    check("multu_busy_fall", 64'(m.busy), 64'd0);
    check("multu_hi", 64'(m.hi), 64'h0000_0001);
    check("multu_lo", 64'(m.lo), 64'hFFFF_FFFE);
    tick();
    check("multu_done_pulse", 64'(m.done), 64'd0);

    run_op("mult_neg",  OP_MULT, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_big",  OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    run_op("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb",  OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu",      OP_DIVU, 32'h1234_5678, 32'h0000_0100, 32'h0000_0078, 32'h0012_3456);
    run_op("divu_zero", OP_DIVU, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run_op("div_zero",  OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI/MTLO write on the accepting edge with no busy.
    issue(OP_MTLO, 32'h0000_1234, 32'd0);
    check("mtlo_lo", 64'(m.lo), 64'h1234);
    check("mtlo_busy", 64'(m.busy), 64'd0);
    issue(OP_MTHI, 32'h0000_ABCD, 32'd0);
    check("mthi_hi", 64'(m.hi), 64'hABCD);
    check("mthi_done", 64'(m.done), 64'd0);

    // MFLO hazard during a MULT; a second start while busy is dropped.
    issue(OP_MULT, 32'd5, 32'd6);
    m.mf_req = 1'b1;
    m.mf_hi  = 1'b0;
    #1;
    check("hz_stall", 64'(m.stall), 64'd1);
    check("hz_result_lo", 64'(m.result), 64'h1234);
    m.mf_hi = 1'b1;
    #1;
    check("hz_result_hi", 64'(m.result), 64'hABCD);
    issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
    check("busy_start_ign", 64'(m.lo), 64'h1234);
    wait_done(cyc, bcnt);
    check("hz_mult_lo", 64'(m.lo), 64'd30);
    check("hz_mult_hi", 64'(m.hi), 64'd0);
    check("hz_stall_clr", 64'(m.stall), 64'd0);
    m.mf_req = 1'b0;
    tick();

    // Asynchronous reset mid-DIVU clears state before the next edge.
    issue(OP_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(m.busy), 64'd0);
    check("arst_done", 64'(m.done), 64'd0);
    check("arst_hi", 64'(m.hi), 64'd0);
    check("arst_lo", 64'(m.lo), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    run_op("divu_after_rst", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);

`ifdef MDU_CANCEL_EN
    issue(OP_MTHI, 32'h55, 32'd0);
    issue(OP_MTLO, 32'h66, 32'd0);
    issue(OP_MULT, 32'd3, 32'd3);
    for (int i = 0; i < 4; i++) tick();
    m.cancel = 1'b1;
    tick();
    m.cancel = 1'b0;
    check("cancel_busy", 64'(m.busy), 64'd0);
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m.done) bcnt++;
    end
    check("cancel_no_done", 64'(bcnt), 64'd0);
    check("cancel_hi", 64'(m.hi), 64'h55);
    check("cancel_lo", 64'(m.lo), 64'h66);
    m.cancel = 1'b1;
    issue(OP_MTLO, 32'h77, 32'd0);
    m.cancel = 1'b0;
    check("cancel_idle_lo", 64'(m.lo), 64'h66);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000 ns");
    $fatal(1);
  end

endmodule
